status_reg: RTL

//  Processor status register (P) of the 6502 datapath. Sits directly downstream
//  of the ALU: it captures N/Z from the ALU result on the SB bus, C from the ALU

---
 rtl/status_reg.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/status_reg.sv
// status_reg: 6502 processor status register (P).
// Holds N,V,D,I,Z,C, updated from the ALU, the data bus and flag opcodes.
// Drives carry-in and decimal-enable back to the ALU and the I mask.
module status_reg #(
  parameter logic [7:0] RST_P = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] aluRes,
  input  logic       aluA7,
  input  logic       aluB7,
  input  logic       aluCout,
  input  logic       isSub,
  input  logic [7:0] dbIn,
  input  logic       ldNZ,
  input  logic       ldC,
  input  logic       ldV,
  input  logic       ldBit,
  input  logic       ldDb,
  input  logic       setC,
  input  logic       clrC,
  input  logic       setI,
  input  logic       clrI,
  input  logic       setD,
  input  logic       clrD,
  input  logic       clrV,
  input  logic       irqAck,
  input  logic       brkPush,
  output logic [7:0] pOut,
  output logic       carry,
  output logic       decEn,
  output logic       irqMask
);

  // Signed overflow from operand and result sign bits.
  function automatic logic v_rule(input logic a7, input logic b7,
                                  input logic r7, input logic sub);
    logic same_sign;
    if (sub) begin
      same_sign = (a7 != b7);
    end else begin
      same_sign = (a7 == b7);
    end
    return same_sign & (r7 != a7);
  endfunction

  // Resolve a set/clear opcode pair; both together leaves the flag alone.
  function automatic logic set_clr(input logic cur, input logic set_f,
                                   input logic clr_f);
    logic res;
    case ({set_f, clr_f})
      2'b10:   res = 1'b1;
      2'b01:   res = 1'b0;
      default: res = cur;
    endcase
    return res;
  endfunction

  logic n_r, v_r, d_r, i_r, z_r, c_r;
  logic n_s, v_s, d_s, i_s, z_s, c_s;
  logic i_src_s;
  logic res_zero_s;

  assign res_zero_s = (aluRes == 8'h00);

  // Next flag values: data-bus load overrides all per-flag sources.
  always_comb begin
    n_s     = n_r;
    v_s     = v_r;
    d_s     = d_r;
    i_src_s = i_r;
    z_s     = z_r;
    c_s     = c_r;
    if (ldDb) begin
      n_s     = dbIn[7];
      v_s     = dbIn[6];
      d_s     = dbIn[3];
      i_src_s = dbIn[2];
      z_s     = dbIn[1];
      c_s     = dbIn[0];
    end else begin
      if (ldC) begin
        c_s = aluCout;
      end else begin
        c_s = set_clr(c_r, setC, clrC);
      end
      if (ldNZ || ldBit) begin
        z_s = res_zero_s;
      end else begin
        z_s = z_r;
      end
      if (ldBit) begin
        n_s = dbIn[7];
      end else if (ldNZ) begin
        n_s = aluRes[7];
      end else begin
        n_s = n_r;
      end
      if (ldBit) begin
        v_s = dbIn[6];
      end else if (ldV) begin
        v_s = v_rule(aluA7, aluB7, aluRes[7], isSub);
      end else if (clrV) begin
        v_s = 1'b0;
      end else begin
        v_s = v_r;
      end
      d_s     = set_clr(d_r, setD, clrD);
      i_src_s = set_clr(i_r, setI, clrI);
    end
  end

  // Interrupt entry masks further IRQs regardless of any other I source.
  always_comb begin
    if (irqAck) begin
      i_s = 1'b1;
    end else begin
      i_s = i_src_s;
    end
  end

  // Flag storage with asynchronous reset to RST_P.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_r <= RST_P[7];
      v_r <= RST_P[6];
      d_r <= RST_P[3];
      i_r <= RST_P[2];
      z_r <= RST_P[1];
      c_r <= RST_P[0];
    end else begin
      n_r <= n_s;
      v_r <= v_s;
      d_r <= d_s;
      i_r <= i_s;
      z_r <= z_s;
      c_r <= c_s;
    end
  end

  // Push image and ALU feedback; bit5 is always 1, B comes only from brkPush.
  always_comb begin
    pOut    = {n_r, v_r, 1'b1, brkPush, d_r, i_r, z_r, c_r};
    carry   = c_r;
    decEn   = d_r;
    irqMask = i_r;
  end

endmodule
